// File: rtl/load_store_unit_if.sv
// Request/response and memory-port bundle for the load/store unit.
// Latency: none, wires only.
// Backpressure: req_ready from the unit; responses and memory have none.
interface load_store_unit_if #(
  parameter int ADDRSIZE     = 64,
  parameter int MEM_ADDRSIZE = 16
);
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_we;
  logic [2:0]              req_funct3;
  logic [ADDRSIZE-1:0]     req_addr;
  logic [63:0]             req_wdata;
  logic                    resp_valid;
  logic [63:0]             resp_rdata;
  logic                    resp_err;
  logic                    mem_rden;
  logic                    mem_wren;
  logic [MEM_ADDRSIZE-1:0] mem_addr;
  logic [63:0]             mem_d;
  logic [63:0]             mem_q;

  // Environment side: issues requests and also plays the memory.
  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_q,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_rden, mem_wren, mem_addr, mem_d
  );

  // Load/store unit side.
  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_q,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_rden, mem_wren, mem_addr, mem_d
  );
endinterface

// File: rtl/load_store_unit.sv
// Byte-addressed RISC-V load/store to 64-bit-word memory, RMW for narrow stores.
// Latency: response 1 (error), 2 (load / SD), 3 (narrow store) cycles after accept.
// Backpressure: one request in flight, req_ready only in IDLE; no response stall.
module load_store_unit #(
  parameter int ADDRSIZE     = 64,
  parameter int MEM_ADDRSIZE = 16
) (
  input logic              clk,
  input logic              rst,
  load_store_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2, RESP = 2'd3} state_t;

  // Only the address bits that reach memory are kept; the upper bits
  // matter solely for the range check made at accept time.
  typedef struct packed {
    logic                    we;
    logic [2:0]              funct3;
    logic [MEM_ADDRSIZE+2:0] addr;
    logic [63:0]             wdata;
  } req_t;

  localparam logic [ADDRSIZE-1:0] HI_MASK = {ADDRSIZE{1'b1}} << (MEM_ADDRSIZE + 3);

  state_t      state_q, state_d;
  req_t        req_q, req_d;
  logic [63:0] data_q, data_d;
  logic [63:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;

  logic                    req_err;
  logic [2:0]              off;
  logic [5:0]              sh_amt;
  logic [MEM_ADDRSIZE-1:0] idx;
  logic [63:0]             size_mask;
  logic [63:0]             merged;
  logic [63:0]             shifted;
  logic [63:0]             load_val;

  function automatic logic access_err(input logic we, input logic [2:0] f3,
                                      input logic [ADDRSIZE-1:0] a);
    logic e;
    e = (f3 == 3'b111) || (we && f3[2]) || ((a & HI_MASK) != '0);
    case (f3[1:0])
      2'b01:   e = e || a[0];
      2'b10:   e = e || (a[1:0] != 2'b00);
      2'b11:   e = e || (a[2:0] != 3'b000);
      default: ;
    endcase
    return e;
  endfunction

  assign req_err = access_err(bus.req_we, bus.req_funct3, bus.req_addr);

  // Decode registered request: lane offset, word index, store merge, load extract.
  always_comb begin
    off    = req_q.addr[2:0];
    sh_amt = {off, 3'b000};
    idx    = req_q.addr[MEM_ADDRSIZE+2:3];
    case (req_q.funct3[1:0])
      2'b00:   size_mask = 64'h0000_0000_0000_00FF;
      2'b01:   size_mask = 64'h0000_0000_0000_FFFF;
      2'b10:   size_mask = 64'h0000_0000_FFFF_FFFF;
      default: size_mask = '1;
    endcase
    // For SD the mask covers every lane, so the stale data word drops out.
    merged  = (data_q & ~(size_mask << sh_amt)) | ((req_q.wdata & size_mask) << sh_amt);
    shifted = bus.mem_q >> sh_amt;
    case (req_q.funct3)
      3'b000:  load_val = {{56{shifted[7]}}, shifted[7:0]};
      3'b001:  load_val = {{48{shifted[15]}}, shifted[15:0]};
      3'b010:  load_val = {{32{shifted[31]}}, shifted[31:0]};
      3'b011:  load_val = shifted;
      3'b100:  load_val = {56'd0, shifted[7:0]};
      3'b101:  load_val = {48'd0, shifted[15:0]};
      3'b110:  load_val = {32'd0, shifted[31:0]};
      default: load_val = '0;
    endcase
  end

  // Next-state: errors skip memory, SD skips the read, everything else reads first.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          if (req_err)                                    state_d = RESP;
          else if (bus.req_we && bus.req_funct3 == 3'b011) state_d = WRITE;
          else                                            state_d = READ;
        end
      end
      READ:    state_d = req_q.we ? WRITE : RESP;
      WRITE:   state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  // Datapath register updates: capture request, read word and response.
  always_comb begin
    req_d        = req_q;
    data_d       = data_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          req_d.we     = bus.req_we;
          req_d.funct3 = bus.req_funct3;
          req_d.addr   = bus.req_addr[MEM_ADDRSIZE+2:0];
          req_d.wdata  = bus.req_wdata;
          if (req_err) begin
            resp_rdata_d = '0;
            resp_err_d   = 1'b1;
          end
        end
      end
      READ: begin
        data_d = bus.mem_q;
        if (!req_q.we) begin
          resp_rdata_d = load_val;
          resp_err_d   = 1'b0;
        end
      end
      WRITE: begin
        resp_rdata_d = '0;
        resp_err_d   = 1'b0;
      end
      default: ;
    endcase
  end

  // Outputs decoded from state; memory strobes fall with the async reset.
  always_comb begin
    bus.req_ready  = (state_q == IDLE);
    bus.resp_valid = (state_q == RESP);
    bus.resp_rdata = resp_rdata_q;
    bus.resp_err   = resp_err_q;
    bus.mem_rden   = (state_q == READ);
    bus.mem_wren   = (state_q == WRITE);
    bus.mem_addr   = (state_q == READ || state_q == WRITE) ? idx : '0;
    bus.mem_d      = (state_q == WRITE) ? merged : '0;
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      req_q        <= '0;
      data_q       <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      data_q       <= data_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed spec cases, reset/busy cases, then random traffic.
// Expected data, errors and cycle timing come from a byte-level memory model.
// The bench plays both requester and 64-bit memory through the interface.
module tb_load_store_unit;
  localparam int AW = 64;
  localparam int MW = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  load_store_unit_if #(.ADDRSIZE(AW), .MEM_ADDRSIZE(MW)) bus ();

  load_store_unit #(.ADDRSIZE(AW), .MEM_ADDRSIZE(MW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  logic [63:0] mem_arr [0:(1<<MW)-1];
  logic [63:0] ref_mem [0:15];

  assign bus.mem_q = mem_arr[bus.mem_addr];

  always @(posedge clk) begin
    if (bus.mem_wren) mem_arr[bus.mem_addr] <= bus.mem_d;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic model_err(input logic we, input logic [2:0] f3, input logic [63:0] addr);
    longint unsigned size;
    size = 64'd1 << f3[1:0];
    return (f3 == 3'd7) || (we && f3 >= 3'd4) || ((addr % size) != 0) || ((addr >> (MW + 3)) != 0);
  endfunction

  function automatic logic [63:0] model_load(input logic [63:0] word, input logic [2:0] f3, input int off);
    int size;
    logic [63:0] v;
    size = 1 << f3[1:0];
    v = '0;
    for (int i = 0; i < size; i++) v[8*i +: 8] = word[8*(off+i) +: 8];
    if (f3 < 3'd4 && size < 8 && v[8*size-1])
      for (int i = size; i < 8; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  // One complete request; checks timing masks over cycles 1..4 after accept.
  task automatic run_req(input logic we, input logic [2:0] f3, input logic [63:0] addr,
                         input logic [63:0] wdata, input string tag, output logic [63:0] rdata_out);
    logic [4:1]  exp_rd, exp_wr, exp_rv, exp_rdy, got_rd, got_wr, got_rv, got_rdy;
    logic [63:0] exp_data, got_data, got_hold;
    logic        exp_err, got_err;
    int          exp_resp, idx, off, waitc;
    idx = int'(addr[MW+2:3]);
    off = int'(addr[2:0]);
    exp_err = model_err(we, f3, addr);
    exp_rd = '0; exp_wr = '0; exp_rv = '0; exp_rdy = '0;
    if (exp_err)               begin exp_resp = 1; end
    else if (!we)              begin exp_resp = 2; exp_rd[1] = 1'b1; end
    else if (f3 == 3'd3)       begin exp_resp = 2; exp_wr[1] = 1'b1; end
    else                       begin exp_resp = 3; exp_rd[1] = 1'b1; exp_wr[2] = 1'b1; end
    exp_rv[exp_resp] = 1'b1;
    for (int k = 1; k <= 4; k++) exp_rdy[k] = (k > exp_resp);
    exp_data = (!exp_err && !we) ? model_load(ref_mem[idx], f3, off) : 64'd0;

    @(negedge clk);
    bus.req_we = we; bus.req_funct3 = f3; bus.req_addr = addr; bus.req_wdata = wdata;
    bus.req_valid = 1'b1;
    waitc = 0;
    while (!bus.req_ready && waitc < 20) begin @(negedge clk); waitc++; end
    chk({tag, " accept"}, 64'(bus.req_ready), 64'd1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;

    got_data = '1; got_err = 1'bx; got_hold = '1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      got_rd[k] = bus.mem_rden; got_wr[k] = bus.mem_wren;
      got_rv[k] = bus.resp_valid; got_rdy[k] = bus.req_ready;
      if (bus.resp_valid) begin got_data = bus.resp_rdata; got_err = bus.resp_err; end
      if (k == 4) got_hold = bus.resp_rdata;
    end
    chk({tag, " rden_cycles"}, 64'(got_rd), 64'(exp_rd));
    chk({tag, " wren_cycles"}, 64'(got_wr), 64'(exp_wr));
    chk({tag, " resp_cycles"}, 64'(got_rv), 64'(exp_rv));
    chk({tag, " ready_cycles"}, 64'(got_rdy), 64'(exp_rdy));
    chk({tag, " rdata"}, got_data, exp_data);
    chk({tag, " err"}, 64'(got_err), 64'(exp_err));
    chk({tag, " rdata_hold"}, got_hold, exp_data);

    if (!exp_err && we)
      for (int i = 0; i < (1 << f3[1:0]); i++) ref_mem[idx][8*(off+i) +: 8] = wdata[8*i +: 8];
    if (idx < 16) chk({tag, " mem_word"}, mem_arr[idx], ref_mem[idx]);
    rdata_out = got_data;
  endtask

  initial begin
    logic [63:0] r, a, wd;
    logic [11:0] rdy_seen, rv_seen, rdy_exp, rv_exp;
    logic        w, rv_any;
    logic [2:0]  f;

    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = '0;
    bus.req_addr = '0; bus.req_wdata = '0;
    for (int i = 0; i < 16; i++) begin
      mem_arr[i] <= 64'd0;
      ref_mem[i] = 64'd0;
    end
    mem_arr[0] <= 64'h8877665544332211;
    ref_mem[0] = 64'h8877665544332211;

    // Reset state
    #2;
    chk("reset ready", 64'(bus.req_ready), 64'd1);
    chk("reset outputs", {58'd0, bus.resp_valid, bus.resp_err, bus.mem_rden, bus.mem_wren, 2'b00}, 64'd0);
    chk("reset rdata", bus.resp_rdata, 64'd0);
    chk("reset mem_addr_d", 64'(bus.mem_addr) | bus.mem_d, 64'd0);
    @(negedge clk); rst = 1'b1;

    // Directed loads from the known word
    run_req(1'b0, 3'd0, 64'h7, 64'd0, "LB7", r);  chk("LB7 value", r, 64'hFFFFFFFFFFFFFF88);
    run_req(1'b0, 3'd4, 64'h7, 64'd0, "LBU7", r); chk("LBU7 value", r, 64'h0000000000000088);
    run_req(1'b0, 3'd1, 64'h2, 64'd0, "LH2", r);  chk("LH2 value", r, 64'h0000000000004433);
    run_req(1'b0, 3'd2, 64'h4, 64'd0, "LW4", r);  chk("LW4 value", r, 64'hFFFFFFFF88776655);
    run_req(1'b0, 3'd6, 64'h4, 64'd0, "LWU4", r); chk("LWU4 value", r, 64'h0000000088776655);

    // Stores
    run_req(1'b1, 3'd1, 64'h2, 64'hABCD, "SH2", r);
    chk("SH2 word0", mem_arr[0], 64'h88776655ABCD2211);
    run_req(1'b1, 3'd3, 64'h8, 64'h0123456789ABCDEF, "SD8", r);
    run_req(1'b0, 3'd3, 64'h8, 64'd0, "LD8", r);  chk("LD8 value", r, 64'h0123456789ABCDEF);

    // Rejected accesses
    run_req(1'b0, 3'd2, 64'h2, 64'd0, "LW_misaligned", r);
    run_req(1'b0, 3'd7, 64'h0, 64'd0, "funct3_111", r);
    run_req(1'b1, 3'd4, 64'h0, 64'h55, "store_f3_100", r);
    run_req(1'b0, 3'd3, 64'd1 << (MW + 3), 64'd0, "addr_out_of_range", r);

    // Reset during WRITE of a narrow store
    @(negedge clk);
    bus.req_we = 1'b1; bus.req_funct3 = 3'd0; bus.req_addr = 64'h0; bus.req_wdata = 64'hEE;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid wren_before", 64'(bus.mem_wren), 64'd1);
    #1 rst = 1'b0;
    #1 chk("rst_mid wren_async", 64'(bus.mem_wren), 64'd0);
    @(posedge clk);
    @(negedge clk); rst = 1'b1;
    rv_any = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      rv_any = rv_any | bus.resp_valid;
    end
    chk("rst_mid no_resp", 64'(rv_any), 64'd0);
    chk("rst_mid ready", 64'(bus.req_ready), 64'd1);
    chk("rst_mid word0", mem_arr[0], ref_mem[0]);
    chk("rst_mid rdata_cleared", bus.resp_rdata, 64'd0);

    // Held req_valid: back-to-back loads, one per 3 cycles
    @(negedge clk);
    bus.req_we = 1'b0; bus.req_funct3 = 3'd3; bus.req_addr = 64'h8; bus.req_wdata = 64'd0;
    bus.req_valid = 1'b1;
    for (int j = 0; j < 12; j++) begin
      if (j > 0) @(negedge clk);
      rdy_seen[j] = bus.req_ready;
      rv_seen[j]  = bus.resp_valid;
      rdy_exp[j]  = (j % 3 == 0);
      rv_exp[j]   = (j % 3 == 2);
    end
    bus.req_valid = 1'b0;
    chk("held ready_pattern", 64'(rdy_seen), 64'(rdy_exp));
    chk("held resp_pattern", 64'(rv_seen), 64'(rv_exp));

    // Random traffic over a few words
    for (int n = 0; n < 300; n++) begin
      w  = 1'($urandom_range(0, 1));
      f  = 3'($urandom_range(0, 7));
      a  = 64'($urandom_range(0, 63));
      if ($urandom_range(0, 9) == 0) a[$urandom_range(MW + 3, 63)] = 1'b1;
      wd = {$urandom, $urandom};
      run_req(w, f, a, wd, $sformatf("rand%0d", n), r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
